// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file constants and types
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_addr_t AUX_REG = reg_addr_t'(15);

endpackage

// File: rtl/reg_pend_tracker.sv
// rtl/reg_pend_tracker.sv - per-register pending-write scoreboard with two lookup ports
module reg_pend_tracker
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  logic      aux_clr_en,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  reg_addr_t look_a,
  input  reg_addr_t look_b,
  output logic      hit_a,
  output logic      hit_b
);

  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pend_next;

  // Clears from both writeback ports first, then the issue-time set so set wins.
  always_comb begin
    pend_next = pend;
    if (clr_en)     pend_next[clr_addr] = 1'b0;
    if (aux_clr_en) pend_next[AUX_REG]  = 1'b0;
    if (set_en)     pend_next[set_addr] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= pend_next;
  end

  assign hit_a = pend[look_a];
  assign hit_b = pend[look_b];

endmodule

// File: rtl/reg_file_wb.sv
// rtl/reg_file_wb.sv - 16x16 GPR file with aux R15 port, write-through bypass and pending flags
module reg_file_wb
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              aux_wr_en,
  input  logic [DATA_W-1:0] aux_wr_data,
  input  logic              set_pend,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              pend_a,
  output logic              pend_b
);

  word_t regs [NUM_REGS];

  // Primary port owns R15 when both ports target it on the same edge.
  logic aux_commit;
  assign aux_commit = aux_wr_en && !(wr_en && (wr_addr == AUX_REG));

  // Storage array: both writeback ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (wr_en)      regs[wr_addr] <= wr_data;
      if (aux_commit) regs[AUX_REG] <= aux_wr_data;
    end
  end

  logic hit_a, hit_b;

  reg_pend_tracker u_pend (
    .clk        (clk),
    .rst        (rst),
    .clr_en     (wr_en),
    .clr_addr   (wr_addr),
    .aux_clr_en (aux_wr_en),
    .set_en     (set_pend),
    .set_addr   (set_addr),
    .look_a     (rd_addr_a),
    .look_b     (rd_addr_b),
    .hit_a      (hit_a),
    .hit_b      (hit_b)
  );

  logic byp_wr_a, byp_wr_b, byp_aux_a, byp_aux_b;
  assign byp_wr_a  = wr_en && (wr_addr == rd_addr_a);
  assign byp_wr_b  = wr_en && (wr_addr == rd_addr_b);
  assign byp_aux_a = aux_wr_en && (rd_addr_a == AUX_REG);
  assign byp_aux_b = aux_wr_en && (rd_addr_b == AUX_REG);

  // Read muxes: primary bypass, then aux bypass, then storage; forced to 0 under reset
  // so a write held during reset never leaks through the bypass.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    pend_a    = hit_a && !(byp_wr_a || byp_aux_a);
    pend_b    = hit_b && !(byp_wr_b || byp_aux_b);
    if (byp_wr_a)       rd_data_a = wr_data;
    else if (byp_aux_a) rd_data_a = aux_wr_data;
    if (byp_wr_b)       rd_data_b = wr_data;
    else if (byp_aux_b) rd_data_b = aux_wr_data;
    if (rst) begin
      rd_data_a = '0;
      rd_data_b = '0;
      pend_a    = 1'b0;
      pend_b    = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// tb/tb_reg_file_wb.sv - directed vector bench for reg_file_wb
module tb_reg_file_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        aux_wr_en;
  logic [15:0] aux_wr_data;
  logic        set_pend;
  logic [3:0]  set_addr;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        pend_a;
  logic        pend_b;

  int passed = 0;
  int total  = 0;

  reg_file_wb dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .aux_wr_en   (aux_wr_en),
    .aux_wr_data (aux_wr_data),
    .set_pend    (set_pend),
    .set_addr    (set_addr),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .rd_data_a   (rd_data_a),
    .rd_data_b   (rd_data_b),
    .pend_a      (pend_a),
    .pend_b      (pend_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        ae;
    logic [15:0] ad;
    logic        sp;
    logic [3:0]  sa;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        epa;
    logic        epb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic we, logic [3:0] wa, logic [15:0] wd,
                              logic ae, logic [15:0] ad, logic sp, logic [3:0] sa,
                              logic [3:0] ra, logic [3:0] rb,
                              logic [15:0] ea, logic [15:0] eb, logic epa, logic epb);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ae = ae; v.ad = ad; v.sp = sp; v.sa = sa;
    v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb; v.epa = epa; v.epb = epb;
    return v;
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
  endtask

  task automatic drive(vec_t v);
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    aux_wr_en = v.ae; aux_wr_data = v.ad;
    set_pend = v.sp; set_addr = v.sa;
    rd_addr_a = v.ra; rd_addr_b = v.rb;
  endtask

  task automatic idle(logic [3:0] ra, logic [3:0] rb);
    drive(mk(0, 0, 0, 0, 0, 0, 0, ra, rb, 0, 0, 0, 0));
  endtask

  initial begin
    rst = 1'b1;
    idle(4'd3, 4'd5);

    //      we wa  wd        ae ad        sp sa  ra  rb  ea        eb        pa pb
    vecs.push_back(mk(0, 0,  16'h0000, 0, 16'h0000, 0, 0,  3,  5,  16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 5,  16'hBEEF, 0, 16'h0000, 0, 0,  5,  0,  16'hBEEF, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0,  16'h0000, 0, 16'h0000, 0, 0,  5,  5,  16'hBEEF, 16'hBEEF, 0, 0));
    vecs.push_back(mk(1, 15, 16'h0001, 1, 16'hFFFF, 0, 0,  15, 15, 16'h0001, 16'h0001, 0, 0));
    vecs.push_back(mk(0, 0,  16'h0000, 0, 16'h0000, 0, 0,  15, 14, 16'h0001, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0,  16'h0000, 0, 16'h0000, 1, 7,  7,  7,  16'h0000, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0,  16'h0000, 0, 16'h0000, 0, 0,  0,  7,  16'h0000, 16'h0000, 0, 1));
    vecs.push_back(mk(1, 7,  16'h00AA, 0, 16'h0000, 0, 0,  7,  7,  16'h00AA, 16'h00AA, 0, 0));
    vecs.push_back(mk(0, 0,  16'h0000, 0, 16'h0000, 0, 0,  7,  7,  16'h00AA, 16'h00AA, 0, 0));
    vecs.push_back(mk(1, 2,  16'h5A5A, 0, 16'h0000, 1, 2,  2,  3,  16'h5A5A, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0,  16'h0000, 0, 16'h0000, 0, 0,  2,  2,  16'h5A5A, 16'h5A5A, 1, 1));
    vecs.push_back(mk(0, 0,  16'h0000, 1, 16'h8000, 0, 0,  15, 15, 16'h8000, 16'h8000, 0, 0));
    vecs.push_back(mk(0, 0,  16'h0000, 0, 16'h0000, 0, 0,  15, 5,  16'h8000, 16'hBEEF, 0, 0));
    vecs.push_back(mk(0, 0,  16'h0000, 0, 16'h0000, 0, 0,  7,  2,  16'h00AA, 16'h5A5A, 0, 1));
    vecs.push_back(mk(0, 0,  16'h0000, 0, 16'h0000, 1, 2,  2,  0,  16'h5A5A, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0,  16'h0000, 0, 16'h0000, 0, 0,  2,  2,  16'h5A5A, 16'h5A5A, 1, 1));
    vecs.push_back(mk(0, 0,  16'h0000, 0, 16'h0000, 1, 15, 15, 14, 16'h8000, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0,  16'h0000, 1, 16'h1111, 0, 0,  15, 14, 16'h1111, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0,  16'h0000, 0, 16'h0000, 0, 0,  15, 1,  16'h1111, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 4,  16'h0044, 0, 16'h0000, 0, 0,  4,  4,  16'h0044, 16'h0044, 0, 0));
    vecs.push_back(mk(0, 0,  16'h0000, 0, 16'h0000, 0, 0,  4,  1,  16'h0044, 16'h0000, 0, 0));

    #2;
    check("rst_hold_rd_a", rd_data_a, 16'h0000);
    check("rst_hold_pend_a", {15'b0, pend_a}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #3;
      check($sformatf("v%0d_rd_a", i), rd_data_a, vecs[i].ea);
      check($sformatf("v%0d_rd_b", i), rd_data_b, vecs[i].eb);
      check($sformatf("v%0d_pend_a", i), {15'b0, pend_a}, {15'b0, vecs[i].epa});
      check($sformatf("v%0d_pend_b", i), {15'b0, pend_b}, {15'b0, vecs[i].epb});
      @(posedge clk);
      #1;
    end

    // Mid-cycle reset with a write in flight and R3 pending.
    drive(mk(1, 3, 16'h1234, 0, 16'h0000, 1, 3, 3, 3, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    idle(4'd3, 4'd7);
    #1;
    check("pre_rst_r3", rd_data_a, 16'h1234);
    check("pre_rst_pend3", {15'b0, pend_a}, 16'h0001);
    check("pre_rst_r7", rd_data_b, 16'h00AA);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h9999;
    #1;
    rst = 1'b1;
    #1;
    check("in_rst_r3", rd_data_a, 16'h0000);
    check("in_rst_pend3", {15'b0, pend_a}, 16'h0000);
    @(negedge clk);
    wr_en = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_r3", rd_data_a, 16'h0000);
    check("post_rst_pend3", {15'b0, pend_a}, 16'h0000);
    check("post_rst_r7", rd_data_b, 16'h0000);
    @(posedge clk);
    #1;
    check("post_rst_edge_r3", rd_data_a, 16'h0000);
    check("post_rst_edge_pend3", {15'b0, pend_a}, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
